mem_arbiter: RTL

//  Shares one Memory instance between two Core requesters: port I (instruction fetch) and port D (data/stack access).

---
 rtl/mem_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port (I fetch, D data) arbiter in front of one Memory, with combinational command routing and read-response steering.
// Optional MEM_ARB_ROUND_ROBIN_EN: alternate grants on conflict; otherwise D has fixed priority over I.
module mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_cmd_start,
  input  logic                  i_cmd_write,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [DATA_WIDTH-1:0] i_wmask,
  output logic                  i_cmd_ready,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_rdata_ready,
  input  logic                  d_cmd_start,
  input  logic                  d_cmd_write,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic [DATA_WIDTH-1:0] d_wmask,
  output logic                  d_cmd_ready,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_rdata_ready,
  output logic                  mem_cmd_start,
  output logic                  mem_cmd_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [DATA_WIDTH-1:0] mem_wmask,
  input  logic                  mem_cmd_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rdata_ready,
  output logic                  err_timeout
);

  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam int CW    = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = TO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RD_WAIT = 1'b1} state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;   // 1 = D owns the outstanding read
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          grant_is_d;
  logic          accept;
  logic          timeout_hit;
  logic          resp;
  logic          start_s;
  logic          i_ready_s, d_ready_s;
  logic          i_rv_s, d_rv_s;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // rr_last_q records the port served by the last accepted command (1 = D)
  logic rr_last_q, rr_last_d;

  always_comb begin
    grant_is_d = d_cmd_start;
    if (i_cmd_start && d_cmd_start) begin
      grant_is_d = ~rr_last_q;
    end else begin
      grant_is_d = d_cmd_start;
    end
  end
`else
  always_comb begin
    grant_is_d = d_cmd_start;
  end
`endif

  // Command routing follows the grant with no register in the path
  assign mem_cmd_write = grant_is_d ? d_cmd_write : i_cmd_write;
  assign mem_addr      = grant_is_d ? d_addr      : i_addr;
  assign mem_wdata     = grant_is_d ? d_wdata     : i_wdata;
  assign mem_wmask     = grant_is_d ? d_wmask     : i_wmask;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    start_s     = 1'b0;
    i_ready_s   = 1'b0;
    d_ready_s   = 1'b0;
    i_rv_s      = 1'b0;
    d_rv_s      = 1'b0;
    accept      = 1'b0;
    timeout_hit = 1'b0;
    resp        = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    rr_last_d   = rr_last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        start_s = i_cmd_start | d_cmd_start;
        if (grant_is_d) begin
          d_ready_s = mem_cmd_ready;
        end else begin
          i_ready_s = mem_cmd_ready;
        end
        accept = start_s & mem_cmd_ready;
        if (accept) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          rr_last_d = grant_is_d;
`endif
          if (!mem_cmd_write) begin
            state_d = ST_RD_WAIT;
            owner_d = grant_is_d;
            cnt_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        if (TO_EN) begin
          cnt_d       = cnt_q + CW'(1);
          timeout_hit = (cnt_q == TO_LAST) & ~mem_rdata_ready;
        end else begin
          cnt_d       = cnt_q;
        end
        resp   = mem_rdata_ready | timeout_hit;
        i_rv_s = resp & ~owner_q;
        d_rv_s = resp & owner_q;
        if (resp) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RD_WAIT;
        end
        if (timeout_hit) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake strobes are held low for the whole time reset is asserted
  assign mem_cmd_start = start_s   & rst_n;
  assign i_cmd_ready   = i_ready_s & rst_n;
  assign d_cmd_ready   = d_ready_s & rst_n;
  assign i_rdata_ready = i_rv_s    & rst_n;
  assign d_rdata_ready = d_rv_s    & rst_n;
  assign i_rdata       = timeout_hit ? '0 : mem_rdata;
  assign d_rdata       = timeout_hit ? '0 : mem_rdata;
  assign err_timeout   = err_q;

  // State, owner, timeout counter and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Round-robin pointer, moved only on accepted commands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_q <= 1'b0;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end
`endif

endmodule
